// File: rtl/scale_mux_arb_pkg.sv
// Shared types and constants for the scale_mux_arbiter slice.
//   state_t : arbiter ownership state (IDLE, OWN_A, OWN_B)
//   SRC_A / SRC_B : source encoding used for SEL, LAST and OUT_SRC
package scale_mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/scale_mux.sv
// Two-input word mux shared by the arbiter.
// Ports:
//   A_DATA, B_DATA : candidate words (Size bits)
//   SEL            : 0 selects A_DATA, 1 selects B_DATA
//   MUX_OUT        : selected word
module scale_mux #(
    parameter int Size = 1
) (
    input  logic [Size-1:0] A_DATA,
    input  logic [Size-1:0] B_DATA,
    input  logic            SEL,
    output logic [Size-1:0] MUX_OUT
);

    assign MUX_OUT = SEL ? B_DATA : A_DATA;

endmodule

// File: rtl/scale_mux_arbiter.sv
// Round-robin arbiter with burst limit in front of a shared scale_mux,
// followed by a one-entry registered output stage.
// Ports:
//   CLK, RST                  : clock, synchronous active-high reset
//   A_DATA/A_VALID/A_READY    : requester A channel
//   B_DATA/B_VALID/B_READY    : requester B channel
//   SEL                       : mux select driven to the datapath (0=A, 1=B)
//   OUT_DATA/OUT_VALID/OUT_READY : registered output channel
//   OUT_SRC                   : which requester produced OUT_DATA
module scale_mux_arbiter
    import scale_mux_arb_pkg::*;
#(
    parameter int Size      = 1,
    parameter int MAX_BURST = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [Size-1:0] A_DATA,
    input  logic            A_VALID,
    output logic            A_READY,
    input  logic [Size-1:0] B_DATA,
    input  logic            B_VALID,
    output logic            B_READY,
    output logic            SEL,
    output logic [Size-1:0] OUT_DATA,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic            OUT_SRC
);

    localparam int            CW   = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] CONE = CW'(1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            sel_q;
    logic            load_en;
    logic            gnt;
    logic            win;
    logic            owned;
    logic [Size-1:0] mux_out;

    // Grant decision. win defaults to the held select so SEL stays
    // defined and stable on cycles without a grant.
    always_comb begin
        load_en = !OUT_VALID || OUT_READY;
        gnt     = 1'b0;
        win     = sel_q;
        owned   = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (!RST && load_en) begin
            if (!A_VALID && !B_VALID) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                gnt = 1'b1;
                // A lone requester always wins; the burst limit only
                // matters while the other side is waiting.
                if (A_VALID && !B_VALID)
                    win = SRC_A;
                else if (B_VALID && !A_VALID)
                    win = SRC_B;
                else if (state_q == OWN_A && cnt_q < CMAX)
                    win = SRC_A;
                else if (state_q == OWN_B && cnt_q < CMAX)
                    win = SRC_B;
                else
                    win = ~last_q;

                owned = (win == SRC_A) ? (state_q == OWN_A) : (state_q == OWN_B);
                // Saturating count: a long lone run must not wrap back
                // under the limit and starve the other side later.
                if (!owned)
                    cnt_d = CONE;
                else if (cnt_q < CMAX)
                    cnt_d = cnt_q + CONE;
                else
                    cnt_d = CMAX;

                state_d = (win == SRC_A) ? OWN_A : OWN_B;
                last_d  = win;
            end
        end
    end

    assign A_READY = gnt && (win == SRC_A);
    assign B_READY = gnt && (win == SRC_B);
    assign SEL     = win;

    scale_mux #(.Size(Size)) u_mux (
        .A_DATA  (A_DATA),
        .B_DATA  (B_DATA),
        .SEL     (SEL),
        .MUX_OUT (mux_out)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= SRC_B;
            sel_q     <= SRC_A;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_SRC   <= SRC_A;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= SEL;
            if (gnt) begin
                OUT_DATA  <= mux_out;
                OUT_SRC   <= win;
                OUT_VALID <= 1'b1;
            end else if (load_en) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scale_mux_arbiter.sv
// Directed self-checking bench for scale_mux_arbiter (Size=8, MAX_BURST=2).
module tb_scale_mux_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] A_DATA, B_DATA;
    logic       A_VALID, B_VALID;
    logic       A_READY, B_READY;
    logic       SEL;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       OUT_SRC;

    int total = 0;
    int bad   = 0;

    int ai = 0;
    int bi = 0;

    scale_mux_arbiter #(.Size(8), .MAX_BURST(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A_DATA    (A_DATA),
        .A_VALID   (A_VALID),
        .A_READY   (A_READY),
        .B_DATA    (B_DATA),
        .B_VALID   (B_VALID),
        .B_READY   (B_READY),
        .SEL       (SEL),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_SRC   (OUT_SRC)
    );

    always #5 CLK = ~CLK;

    // Requester protocol and one-hot READY monitor.
    logic       a_pend = 1'b0, b_pend = 1'b0;
    logic [7:0] a_hold = 8'h00, b_hold = 8'h00;
    always @(posedge CLK) begin
        total = total + 1;
        if (A_READY && B_READY) begin
            bad = bad + 1;
            $display("FAIL onehot_ready: got A_READY=%b B_READY=%b want at most one", A_READY, B_READY);
        end
        if (!RST && a_pend) begin
            total = total + 1;
            if (!(A_VALID && A_DATA === a_hold)) begin
                bad = bad + 1;
                $display("FAIL a_protocol: got valid=%b data=%h want 1 %h", A_VALID, A_DATA, a_hold);
            end
        end
        if (!RST && b_pend) begin
            total = total + 1;
            if (!(B_VALID && B_DATA === b_hold)) begin
                bad = bad + 1;
                $display("FAIL b_protocol: got valid=%b data=%h want 1 %h", B_VALID, B_DATA, b_hold);
            end
        end
        a_pend <= !RST && A_VALID && !A_READY;
        b_pend <= !RST && B_VALID && !B_READY;
        a_hold <= A_DATA;
        b_hold <= B_DATA;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; OUT_READY = 1'b1;
        A_VALID = 1'b1; A_DATA = 8'h11;
        B_VALID = 1'b1; B_DATA = 8'h22;
        for (int i = 0; i < 3; i++) begin
            tick();
            total = total + 1;
            if (A_READY !== 1'b0 || B_READY !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL reset_ready: got %b%b want 00", A_READY, B_READY);
            end
            total = total + 1;
            if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00 || OUT_SRC !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL reset_out: got v=%b d=%h s=%b want 0 00 0", OUT_VALID, OUT_DATA, OUT_SRC);
            end
        end
        RST = 1'b0; #1;
        total = total + 1;
        if (A_READY !== 1'b1 || B_READY !== 1'b0 || SEL !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_first_grant: got a=%b b=%b sel=%b want 1 0 0", A_READY, B_READY, SEL);
        end
        tick();
        total = total + 1;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h11 || OUT_SRC !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_first_out: got v=%b d=%h s=%b want 1 11 0", OUT_VALID, OUT_DATA, OUT_SRC);
        end
        A_VALID = 1'b0; #1;
        total = total + 1;
        if (A_READY !== 1'b0 || B_READY !== 1'b1 || SEL !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL reset_b_grant: got a=%b b=%b sel=%b want 0 1 1", A_READY, B_READY, SEL);
        end
        tick();
        total = total + 1;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h22 || OUT_SRC !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL reset_b_out: got v=%b d=%h s=%b want 1 22 1", OUT_VALID, OUT_DATA, OUT_SRC);
        end
        B_VALID = 1'b0; #1;
        total = total + 1;
        if (A_READY !== 1'b0 || B_READY !== 1'b0 || SEL !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL idle_hold: got a=%b b=%b sel=%b want 0 0 1", A_READY, B_READY, SEL);
        end
        tick();
        total = total + 1;
        if (OUT_VALID !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL drain: got v=%b want 0", OUT_VALID);
        end
    endtask

    task automatic test_contention();
        logic       es [6];
        logic [7:0] ed [6];
        es = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ed = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3};
        ai = 0; bi = 0;
        A_VALID = 1'b1; B_VALID = 1'b1;
        for (int k = 0; k < 6; k++) begin
            A_DATA = 8'(8'hA0 + ai);
            B_DATA = 8'(8'hB0 + bi);
            #1;
            total = total + 1;
            if (A_READY !== ~es[k] || B_READY !== es[k] || SEL !== es[k]) begin
                bad = bad + 1;
                $display("FAIL contention_grant[%0d]: got a=%b b=%b sel=%b want sel=%b", k, A_READY, B_READY, SEL, es[k]);
            end
            if (A_READY) ai++;
            if (B_READY) bi++;
            tick();
            total = total + 1;
            if (OUT_VALID !== 1'b1 || OUT_SRC !== es[k] || OUT_DATA !== ed[k]) begin
                bad = bad + 1;
                $display("FAIL contention_out[%0d]: got v=%b s=%b d=%h want 1 %b %h", k, OUT_VALID, OUT_SRC, OUT_DATA, es[k], ed[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic       es [4];
        logic [7:0] ed [4];
        es = '{1'b1, 1'b1, 1'b0, 1'b0};
        ed = '{8'hB2, 8'hB3, 8'hA4, 8'hA5};
        OUT_READY = 1'b0;
        A_DATA = 8'(8'hA0 + ai);
        B_DATA = 8'(8'hB0 + bi);
        #1;
        for (int k = 0; k < 4; k++) begin
            total = total + 1;
            if (A_READY !== 1'b0 || B_READY !== 1'b0 || SEL !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL stall_ready[%0d]: got a=%b b=%b sel=%b want 0 0 0", k, A_READY, B_READY, SEL);
            end
            total = total + 1;
            if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'hA3 || OUT_SRC !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL stall_out[%0d]: got v=%b d=%h s=%b want 1 a3 0", k, OUT_VALID, OUT_DATA, OUT_SRC);
            end
            tick();
        end
        OUT_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            A_DATA = 8'(8'hA0 + ai);
            B_DATA = 8'(8'hB0 + bi);
            #1;
            total = total + 1;
            if (A_READY !== ~es[k] || B_READY !== es[k] || SEL !== es[k]) begin
                bad = bad + 1;
                $display("FAIL resume_grant[%0d]: got a=%b b=%b sel=%b want sel=%b", k, A_READY, B_READY, SEL, es[k]);
            end
            if (A_READY) ai++;
            if (B_READY) bi++;
            tick();
            total = total + 1;
            if (OUT_VALID !== 1'b1 || OUT_SRC !== es[k] || OUT_DATA !== ed[k]) begin
                bad = bad + 1;
                $display("FAIL resume_out[%0d]: got v=%b s=%b d=%h want 1 %b %h", k, OUT_VALID, OUT_SRC, OUT_DATA, es[k], ed[k]);
            end
        end
    endtask

    task automatic test_lone_b();
        logic [7:0] want;
        A_VALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            B_DATA = 8'(8'hB0 + bi);
            want   = B_DATA;
            #1;
            total = total + 1;
            if (B_READY !== 1'b1 || A_READY !== 1'b0 || SEL !== 1'b1) begin
                bad = bad + 1;
                $display("FAIL lone_b_grant[%0d]: got a=%b b=%b sel=%b want 0 1 1", k, A_READY, B_READY, SEL);
            end
            if (B_READY) bi++;
            tick();
            total = total + 1;
            if (OUT_VALID !== 1'b1 || OUT_SRC !== 1'b1 || OUT_DATA !== want) begin
                bad = bad + 1;
                $display("FAIL lone_b_out[%0d]: got v=%b s=%b d=%h want 1 1 %h", k, OUT_VALID, OUT_SRC, OUT_DATA, want);
            end
        end
        // Count sits at the limit: a newly waiting A must win at once.
        A_VALID = 1'b1; A_DATA = 8'hC0; B_DATA = 8'(8'hB0 + bi);
        #1;
        total = total + 1;
        if (A_READY !== 1'b1 || B_READY !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL saturate_switch: got a=%b b=%b want 1 0", A_READY, B_READY);
        end
        tick();
        total = total + 1;
        if (OUT_DATA !== 8'hC0 || OUT_SRC !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL saturate_out: got d=%h s=%b want c0 0", OUT_DATA, OUT_SRC);
        end
        A_VALID = 1'b0; #1;
        total = total + 1;
        if (B_READY !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL saturate_b_back: got b=%b want 1", B_READY);
        end
        tick();
        total = total + 1;
        if (OUT_DATA !== 8'hB9 || OUT_SRC !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL saturate_b_out: got d=%h s=%b want b9 1", OUT_DATA, OUT_SRC);
        end
        B_VALID = 1'b0;
        tick();
        total = total + 1;
        if (OUT_VALID !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL lone_b_drain: got v=%b want 0", OUT_VALID);
        end
    endtask

    task automatic test_lone_a();
        A_VALID = 1'b1; A_DATA = 8'h55;
        #1;
        total = total + 1;
        if (A_READY !== 1'b1 || B_READY !== 1'b0 || SEL !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL lone_a_grant: got a=%b b=%b sel=%b want 1 0 0", A_READY, B_READY, SEL);
        end
        tick();
        total = total + 1;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h55 || OUT_SRC !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL lone_a_out: got v=%b d=%h s=%b want 1 55 0", OUT_VALID, OUT_DATA, OUT_SRC);
        end
        A_VALID = 1'b0;
        tick();
        total = total + 1;
        if (OUT_VALID !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL lone_a_drain: got v=%b want 0", OUT_VALID);
        end
    endtask

    task automatic test_mid_reset();
        // Two A grants leave A at its burst limit with LAST=A, so only a
        // real reset lets A win the next contest.
        A_VALID = 1'b1; A_DATA = 8'h76;
        tick();
        A_DATA = 8'h77;
        #1;
        total = total + 1;
        if (A_READY !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL midrst_setup: got a=%b want 1", A_READY);
        end
        tick();
        RST = 1'b1; OUT_READY = 1'b0;
        A_DATA = 8'h81; B_VALID = 1'b1; B_DATA = 8'h91;
        #1;
        total = total + 1;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h77 || A_READY !== 1'b0 || B_READY !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL midrst_pre: got v=%b d=%h a=%b b=%b want 1 77 0 0", OUT_VALID, OUT_DATA, A_READY, B_READY);
        end
        tick();
        total = total + 1;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00) begin
            bad = bad + 1;
            $display("FAIL midrst_drop: got v=%b d=%h want 0 00", OUT_VALID, OUT_DATA);
        end
        RST = 1'b0; OUT_READY = 1'b1;
        #1;
        total = total + 1;
        if (A_READY !== 1'b1 || B_READY !== 1'b0 || SEL !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL midrst_a_first: got a=%b b=%b sel=%b want 1 0 0", A_READY, B_READY, SEL);
        end
        tick();
        total = total + 1;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h81 || OUT_SRC !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL midrst_a_out: got v=%b d=%h s=%b want 1 81 0", OUT_VALID, OUT_DATA, OUT_SRC);
        end
        A_VALID = 1'b0;
        tick();
        total = total + 1;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h91 || OUT_SRC !== 1'b1) begin
            bad = bad + 1;
            $display("FAIL midrst_b_out: got v=%b d=%h s=%b want 1 91 1", OUT_VALID, OUT_DATA, OUT_SRC);
        end
        B_VALID = 1'b0;
        tick();
        total = total + 1;
        if (OUT_VALID !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL midrst_drain: got v=%b want 0", OUT_VALID);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_stall();
        test_lone_b();
        test_lone_a();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
